// File: rtl/apb4_gpio_v2_pkg.sv
// Shared constants for the APB4 GPIO v2 block: register offsets, DBCTRL
// field layout and the interrupt-type encoding.
package gpio_v2_pkg;

   localparam logic [3:0] OFF_PADDIR   = 4'd0;
   localparam logic [3:0] OFF_PADIN    = 4'd1;
   localparam logic [3:0] OFF_PADOUT   = 4'd2;
   localparam logic [3:0] OFF_PADSET   = 4'd3;
   localparam logic [3:0] OFF_PADCLR   = 4'd4;
   localparam logic [3:0] OFF_INTEN    = 4'd5;
   localparam logic [3:0] OFF_INTTYPE0 = 4'd6;
   localparam logic [3:0] OFF_INTTYPE1 = 4'd7;
   localparam logic [3:0] OFF_INTANY   = 4'd8;
   localparam logic [3:0] OFF_INTSTAT  = 4'd9;
   localparam logic [3:0] OFF_IOFCFG   = 4'd10;
   localparam logic [3:0] OFF_PINMUX   = 4'd11;
   localparam logic [3:0] OFF_DBEN     = 4'd12;
   localparam logic [3:0] OFF_DBCTRL   = 4'd13;

   localparam int DB_PRESC_LSB  = 0;
   localparam int DB_PRESC_W    = 16;
   localparam int DB_THRESH_LSB = 16;

   // {INTTYPE1, INTTYPE0} per pin, used when INTANY is clear
   typedef enum logic [1:0] {
      INT_LVL_HIGH = 2'b00,
      INT_LVL_LOW  = 2'b01,
      INT_RISE     = 2'b10,
      INT_FALL     = 2'b11
   } int_type_e;

endpackage

// File: rtl/apb4_gpio_v2_if.sv
// APB4 completer-side bus bundle for the GPIO block.
// Handshake: a transfer completes in the cycle psel & penable are high;
// pready is always 1, so there are no wait states and pslverr is never set.
interface apb4_gpio_v2_if;
   logic [31:0] paddr;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [31:0] pwdata;
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;

   modport master (
      output paddr, psel, penable, pwrite, pwdata,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  paddr, psel, penable, pwrite, pwdata,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/apb4_gpio_v2_debounce.sv
// Per-pin debounce filter: a shared prescaler ticks the per-pin stability
// counters; a pin's filtered value follows its input after THRESH stable ticks.
module gpio_debounce #(
   parameter int PIN_NUM  = 32,
   parameter int DB_CNT_W = 4
) (
   input  logic                pclk,
   input  logic                preset,
   input  logic                i_clr,
   input  logic [PIN_NUM-1:0]  i_en,
   input  logic [PIN_NUM-1:0]  i_sync,
   input  logic [15:0]         i_presc,
   input  logic [DB_CNT_W-1:0] i_thresh,
   output logic [PIN_NUM-1:0]  o_filt
);

   logic [15:0]                      r_presc;
   logic [PIN_NUM-1:0][DB_CNT_W-1:0] r_cnt;
   logic [PIN_NUM-1:0]               r_filt;
   logic                             w_tick;
   logic [DB_CNT_W-1:0]              w_thr;
   logic [PIN_NUM-1:0][DB_CNT_W-1:0] w_cnt_inc;

   assign w_tick = (r_presc == i_presc);
   assign w_thr  = (i_thresh == '0) ? DB_CNT_W'(1) : i_thresh;
   assign o_filt = r_filt;

   always_comb begin
      w_cnt_inc = '0;
      for (int i = 0; i < PIN_NUM; i++) begin
         w_cnt_inc[i] = (&r_cnt[i]) ? r_cnt[i] : r_cnt[i] + DB_CNT_W'(1);
      end
   end

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         r_presc <= '0;
         r_cnt   <= '0;
         r_filt  <= '0;
      end else begin
         if (i_clr || w_tick) r_presc <= '0;
         else                 r_presc <= r_presc + 16'd1;
         for (int i = 0; i < PIN_NUM; i++) begin
            // Disabled pins track the input so enabling later starts from a settled value
            if (!i_en[i]) begin
               r_cnt[i]  <= '0;
               r_filt[i] <= i_sync[i];
            end else if (i_clr) begin
               r_cnt[i] <= '0;
            end else if (w_tick) begin
               if (i_sync[i] == r_filt[i]) begin
                  r_cnt[i] <= '0;
               end else if (w_cnt_inc[i] == w_thr) begin
                  r_filt[i] <= i_sync[i];
                  r_cnt[i]  <= '0;
               end else begin
                  r_cnt[i] <= w_cnt_inc[i];
               end
            end
         end
      end
   end

endmodule

// File: rtl/apb4_gpio_v2.sv
// APB4 GPIO controller: synchronised/debounced inputs, atomic set/clear outputs,
// sticky W1C interrupts with level/edge/any-edge modes, and alternate-function muxing.
module apb4_gpio_v2
   import gpio_v2_pkg::*;
#(
   parameter int PIN_NUM    = 32,
   parameter int SYNC_STAGE = 2,
   parameter int DB_CNT_W   = 4
) (
   input  logic               pclk,
   input  logic               preset,
   apb4_gpio_v2_if.slave      apb,
   input  logic [PIN_NUM-1:0] gpio_in_i,
   output logic [PIN_NUM-1:0] gpio_out_o,
   output logic [PIN_NUM-1:0] gpio_dir_o,
   output logic [PIN_NUM-1:0] gpio_alt_in_o,
   input  logic [PIN_NUM-1:0] gpio_alt_0_out_i,
   input  logic [PIN_NUM-1:0] gpio_alt_1_out_i,
   input  logic [PIN_NUM-1:0] gpio_alt_0_dir_i,
   input  logic [PIN_NUM-1:0] gpio_alt_1_dir_i,
   output logic               irq_o
);

   logic [PIN_NUM-1:0] r_paddir, r_padout, r_inten, r_inttype0, r_inttype1;
   logic [PIN_NUM-1:0] r_intany, r_intstat, r_iofcfg, r_pinmux, r_dben;
   logic [15:0]         r_presc;
   logic [DB_CNT_W-1:0] r_thresh;
   logic [SYNC_STAGE-1:0][PIN_NUM-1:0] r_sync;
   logic [PIN_NUM-1:0] r_prev;

   logic               w_wr, w_rd, w_db_clr, w_unused_bits;
   logic [3:0]         w_off;
   logic [PIN_NUM-1:0] w_wdata, w_s_sync, w_db_filt, w_filt;
   logic [PIN_NUM-1:0] w_rise, w_fall, w_trg, w_w1c, w_alt_out, w_alt_dir;
   logic [31:0]        w_rdata;

   assign w_wr     = apb.psel & apb.penable & apb.pwrite;
   assign w_rd     = apb.psel & apb.penable & ~apb.pwrite;
   assign w_off    = apb.paddr[5:2];
   assign w_wdata  = apb.pwdata[PIN_NUM-1:0];
   assign w_db_clr = w_wr && (w_off == OFF_DBCTRL);
   assign w_w1c    = (w_wr && (w_off == OFF_INTSTAT)) ? w_wdata : '0;
   assign w_unused_bits = ^{apb.paddr[31:6], apb.paddr[1:0], apb.pwdata};

   assign apb.pready  = 1'b1;
   assign apb.pslverr = 1'b0;
   assign apb.prdata  = w_rd ? w_rdata : 32'd0;

   assign w_s_sync = r_sync[SYNC_STAGE-1];

   gpio_debounce #(
      .PIN_NUM  (PIN_NUM),
      .DB_CNT_W (DB_CNT_W)
   ) u_debounce (
      .pclk     (pclk),
      .preset   (preset),
      .i_clr    (w_db_clr),
      .i_en     (r_dben),
      .i_sync   (w_s_sync),
      .i_presc  (r_presc),
      .i_thresh (r_thresh),
      .o_filt   (w_db_filt)
   );

   assign w_filt        = (r_dben & w_db_filt) | (~r_dben & w_s_sync);
   assign gpio_alt_in_o = w_filt;
   assign w_rise        = w_filt & ~r_prev;
   assign w_fall        = ~w_filt & r_prev;

   always_comb begin
      w_trg = '0;
      for (int i = 0; i < PIN_NUM; i++) begin
         if (r_intany[i]) begin
            w_trg[i] = w_rise[i] | w_fall[i];
         end else begin
            case (int_type_e'({r_inttype1[i], r_inttype0[i]}))
               INT_LVL_HIGH: w_trg[i] = w_filt[i];
               INT_LVL_LOW:  w_trg[i] = ~w_filt[i];
               INT_RISE:     w_trg[i] = w_rise[i];
               default:      w_trg[i] = w_fall[i];
            endcase
         end
      end
   end

   always_comb begin
      w_rdata = '0;
      case (w_off)
         OFF_PADDIR:   w_rdata = 32'(r_paddir);
         OFF_PADIN:    w_rdata = 32'(w_filt);
         OFF_PADOUT:   w_rdata = 32'(r_padout);
         OFF_INTEN:    w_rdata = 32'(r_inten);
         OFF_INTTYPE0: w_rdata = 32'(r_inttype0);
         OFF_INTTYPE1: w_rdata = 32'(r_inttype1);
         OFF_INTANY:   w_rdata = 32'(r_intany);
         OFF_INTSTAT:  w_rdata = 32'(r_intstat);
         OFF_IOFCFG:   w_rdata = 32'(r_iofcfg);
         OFF_PINMUX:   w_rdata = 32'(r_pinmux);
         OFF_DBEN:     w_rdata = 32'(r_dben);
         OFF_DBCTRL: begin
            w_rdata[DB_PRESC_LSB +: DB_PRESC_W] = r_presc;
            w_rdata[DB_THRESH_LSB +: DB_CNT_W]  = r_thresh;
         end
         default:      w_rdata = '0;
      endcase
   end

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         r_paddir   <= '0;
         r_padout   <= '0;
         r_inten    <= '0;
         r_inttype0 <= '0;
         r_inttype1 <= '0;
         r_intany   <= '0;
         r_intstat  <= '0;
         r_iofcfg   <= '0;
         r_pinmux   <= '0;
         r_dben     <= '0;
         r_presc    <= '0;
         r_thresh   <= '0;
         r_sync     <= '0;
         r_prev     <= '0;
      end else begin
         if (w_wr) begin
            case (w_off)
               OFF_PADDIR:   r_paddir   <= w_wdata;
               OFF_PADOUT:   r_padout   <= w_wdata;
               OFF_PADSET:   r_padout   <= r_padout | w_wdata;
               OFF_PADCLR:   r_padout   <= r_padout & ~w_wdata;
               OFF_INTEN:    r_inten    <= w_wdata;
               OFF_INTTYPE0: r_inttype0 <= w_wdata;
               OFF_INTTYPE1: r_inttype1 <= w_wdata;
               OFF_INTANY:   r_intany   <= w_wdata;
               OFF_IOFCFG:   r_iofcfg   <= w_wdata;
               OFF_PINMUX:   r_pinmux   <= w_wdata;
               OFF_DBEN:     r_dben     <= w_wdata;
               OFF_DBCTRL: begin
                  r_presc  <= apb.pwdata[DB_PRESC_LSB +: DB_PRESC_W];
                  r_thresh <= apb.pwdata[DB_THRESH_LSB +: DB_CNT_W];
               end
               default: ;
            endcase
         end
         // A new trigger in the same cycle as a W1C keeps the bit set
         r_intstat <= (r_intstat & ~w_w1c) | (r_inten & w_trg);
         r_sync[0] <= gpio_in_i;
         for (int k = 1; k < SYNC_STAGE; k++) r_sync[k] <= r_sync[k-1];
         r_prev <= w_filt;
      end
   end

   assign irq_o = |r_intstat;

   assign w_alt_out  = (r_pinmux & gpio_alt_1_out_i) | (~r_pinmux & gpio_alt_0_out_i);
   assign w_alt_dir  = (r_pinmux & gpio_alt_1_dir_i) | (~r_pinmux & gpio_alt_0_dir_i);
   assign gpio_out_o = (r_iofcfg & w_alt_out) | (~r_iofcfg & r_padout);
   assign gpio_dir_o = (r_iofcfg & w_alt_dir) | (~r_iofcfg & r_paddir);

endmodule

// File: tb/tb_apb4_gpio_v2.sv
// Self-checking bench for apb4_gpio_v2: register map, set/clear, interrupt
// modes and latency, debounce filtering, alternate-function mux and async reset.
module tb_apb4_gpio_v2;
   localparam int PIN_NUM    = 32;
   localparam int SYNC_STAGE = 2;
   localparam int DB_CNT_W   = 4;

   logic               pclk = 1'b0;
   logic               preset;
   logic [PIN_NUM-1:0] gpio_in, gpio_out, gpio_dir, gpio_alt_in;
   logic [PIN_NUM-1:0] alt0_out, alt1_out, alt0_dir, alt1_dir;
   logic               irq;
   logic [31:0]        exp_q[$];
   int                 n_checks = 0;
   int                 n_fail   = 0;

   apb4_gpio_v2_if bus();

   apb4_gpio_v2 #(
      .PIN_NUM    (PIN_NUM),
      .SYNC_STAGE (SYNC_STAGE),
      .DB_CNT_W   (DB_CNT_W)
   ) dut (
      .pclk             (pclk),
      .preset           (preset),
      .apb              (bus),
      .gpio_in_i        (gpio_in),
      .gpio_out_o       (gpio_out),
      .gpio_dir_o       (gpio_dir),
      .gpio_alt_in_o    (gpio_alt_in),
      .gpio_alt_0_out_i (alt0_out),
      .gpio_alt_1_out_i (alt1_out),
      .gpio_alt_0_dir_i (alt0_dir),
      .gpio_alt_1_dir_i (alt1_dir),
      .irq_o            (irq)
   );

   // clock / reset
   always #5 pclk = ~pclk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
      $fatal(1, "watchdog");
   end

   // driver tasks
   task automatic apb_write(input logic [3:0] off, input logic [31:0] d);
      @(negedge pclk);
      bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
      bus.paddr = {26'd0, off, 2'b00}; bus.pwdata = d;
      @(negedge pclk);
      bus.penable = 1'b1;
      @(negedge pclk);
      bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
   endtask

   task automatic apb_read(input logic [3:0] off, output logic [31:0] d);
      @(negedge pclk);
      bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0;
      bus.paddr = {26'd0, off, 2'b00};
      @(negedge pclk);
      bus.penable = 1'b1;
      #1 d = bus.prdata;
      @(negedge pclk);
      bus.psel = 1'b0; bus.penable = 1'b0;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge pclk);
   endtask

   task automatic test_reset();
      logic [31:0] rd, ev;
      preset = 1'b1;
      wait_cycles(3);
      preset = 1'b0;
      #1;
      exp_q.push_back(32'd0);
      ev = exp_q.pop_front(); n_checks++;
      if ({31'd0, irq} !== ev) begin n_fail++; $display("FAIL reset_irq got=%h exp=%h", irq, ev); end
      exp_q.push_back(32'd0);
      ev = exp_q.pop_front(); n_checks++;
      if (32'(gpio_out) !== ev) begin n_fail++; $display("FAIL reset_out got=%h exp=%h", gpio_out, ev); end
      exp_q.push_back(32'd0);
      ev = exp_q.pop_front(); n_checks++;
      if (32'(gpio_dir) !== ev) begin n_fail++; $display("FAIL reset_dir got=%h exp=%h", gpio_dir, ev); end
      for (int off = 0; off < 16; off++) begin
         exp_q.push_back(32'd0);
         apb_read(4'(off), rd);
         ev = exp_q.pop_front(); n_checks++;
         if (rd !== ev) begin n_fail++; $display("FAIL reset_rd off=%0d got=%h exp=%h", off, rd, ev); end
      end
   endtask

   task automatic test_set_clr();
      logic [31:0] rd, ev;
      apb_write(4'd2, 32'h0000_00F0);
      apb_write(4'd3, 32'h0000_000F);
      apb_write(4'd4, 32'h0000_0030);
      exp_q.push_back(32'h0000_00CF);
      apb_read(4'd2, rd);
      ev = exp_q.pop_front(); n_checks++;
      if (rd !== ev) begin n_fail++; $display("FAIL padout_rd got=%h exp=%h", rd, ev); end
      exp_q.push_back(32'h0000_00CF);
      ev = exp_q.pop_front(); n_checks++;
      if (32'(gpio_out) !== ev) begin n_fail++; $display("FAIL padout_pin got=%h exp=%h", gpio_out, ev); end
      exp_q.push_back(32'd0);
      apb_read(4'd3, rd);
      ev = exp_q.pop_front(); n_checks++;
      if (rd !== ev) begin n_fail++; $display("FAIL padset_rd got=%h exp=%h", rd, ev); end
      apb_write(4'd1, 32'hFFFF_FFFF);
      exp_q.push_back(32'd0);
      apb_read(4'd1, rd);
      ev = exp_q.pop_front(); n_checks++;
      if (rd !== ev) begin n_fail++; $display("FAIL padin_ro got=%h exp=%h", rd, ev); end
      apb_write(4'd0, 32'h0000_00A5);
      exp_q.push_back(32'h0000_00A5);
      ev = exp_q.pop_front(); n_checks++;
      if (32'(gpio_dir) !== ev) begin n_fail++; $display("FAIL paddir_pin got=%h exp=%h", gpio_dir, ev); end
      apb_write(4'd0, 32'd0);
      apb_write(4'd13, 32'hFFFF_FFFF);
      exp_q.push_back(32'h000F_FFFF);
      apb_read(4'd13, rd);
      ev = exp_q.pop_front(); n_checks++;
      if (rd !== ev) begin n_fail++; $display("FAIL dbctrl_rd got=%h exp=%h", rd, ev); end
      apb_write(4'd13, 32'd0);
   endtask

   task automatic test_rise_latency();
      logic [31:0] rd, ev;
      apb_write(4'd7, 32'h1);
      apb_write(4'd6, 32'h0);
      apb_write(4'd5, 32'h1);
      @(negedge pclk);
      gpio_in[0] = 1'b1;
      for (int c = 1; c <= SYNC_STAGE + 1; c++) begin
         exp_q.push_back((c >= SYNC_STAGE + 1) ? 32'd1 : 32'd0);
         @(posedge pclk);
         #1;
         ev = exp_q.pop_front(); n_checks++;
         if ({31'd0, irq} !== ev) begin n_fail++; $display("FAIL rise_irq cyc=%0d got=%h exp=%h", c, irq, ev); end
      end
      exp_q.push_back(32'h1);
      apb_read(4'd9, rd);
      ev = exp_q.pop_front(); n_checks++;
      if (rd !== ev) begin n_fail++; $display("FAIL rise_stat got=%h exp=%h", rd, ev); end
      apb_write(4'd9, 32'h1);
      exp_q.push_back(32'h0);
      apb_read(4'd9, rd);
      ev = exp_q.pop_front(); n_checks++;
      if (rd !== ev || irq !== 1'b0) begin n_fail++; $display("FAIL rise_w1c got=%h irq=%b exp=%h", rd, irq, ev); end
      gpio_in[0] = 1'b0;
      wait_cycles(SYNC_STAGE + 3);
      exp_q.push_back(32'h0);
      apb_read(4'd9, rd);
      ev = exp_q.pop_front(); n_checks++;
      if (rd !== ev) begin n_fail++; $display("FAIL rise_nofall got=%h exp=%h", rd, ev); end
      apb_write(4'd5, 32'h0);
   endtask

   task automatic test_any_edge();
      logic [31:0] rd, ev;
      apb_write(4'd8, 32'h4);
      apb_write(4'd5, 32'h4);
      gpio_in[2] = 1'b1;
      wait_cycles(SYNC_STAGE + 3);
      exp_q.push_back(32'h4);
      apb_read(4'd9, rd);
      ev = exp_q.pop_front(); n_checks++;
      if (rd !== ev) begin n_fail++; $display("FAIL any_rise got=%h exp=%h", rd, ev); end
      apb_write(4'd9, 32'h4);
      exp_q.push_back(32'h0);
      apb_read(4'd9, rd);
      ev = exp_q.pop_front(); n_checks++;
      if (rd !== ev) begin n_fail++; $display("FAIL any_clr got=%h exp=%h", rd, ev); end
      gpio_in[2] = 1'b0;
      wait_cycles(SYNC_STAGE + 3);
      exp_q.push_back(32'h4);
      apb_read(4'd9, rd);
      ev = exp_q.pop_front(); n_checks++;
      if (rd !== ev) begin n_fail++; $display("FAIL any_fall got=%h exp=%h", rd, ev); end
      apb_write(4'd9, 32'h4);
      apb_write(4'd5, 32'h0);
      apb_write(4'd8, 32'h0);
   endtask

   task automatic test_level();
      logic [31:0] rd, ev;
      apb_write(4'd5, 32'h8);
      gpio_in[3] = 1'b1;
      wait_cycles(SYNC_STAGE + 3);
      apb_write(4'd9, 32'h8);
      exp_q.push_back(32'h8);
      apb_read(4'd9, rd);
      ev = exp_q.pop_front(); n_checks++;
      if (rd !== ev || irq !== 1'b1) begin n_fail++; $display("FAIL level_reset got=%h irq=%b exp=%h", rd, irq, ev); end
      gpio_in[3] = 1'b0;
      wait_cycles(SYNC_STAGE + 3);
      apb_write(4'd9, 32'h8);
      exp_q.push_back(32'h0);
      apb_read(4'd9, rd);
      ev = exp_q.pop_front(); n_checks++;
      if (rd !== ev || irq !== 1'b0) begin n_fail++; $display("FAIL level_release got=%h irq=%b exp=%h", rd, irq, ev); end
      apb_write(4'd5, 32'h0);
   endtask

   task automatic test_debounce();
      logic [31:0] rd, ev;
      logic        seen;
      int          lat;
      apb_write(4'd13, 32'h0004_0003);
      apb_write(4'd12, 32'h1);
      wait_cycles(10);
      seen = 1'b0;
      @(negedge pclk);
      gpio_in[0] = 1'b1;
      for (int c = 0; c < 32; c++) begin
         if (c == 8) gpio_in[0] = 1'b0;
         @(posedge pclk);
         #1 if (gpio_alt_in[0]) seen = 1'b1;
         @(negedge pclk);
      end
      exp_q.push_back(32'd0);
      ev = exp_q.pop_front(); n_checks++;
      if ({31'd0, seen} !== ev) begin n_fail++; $display("FAIL db_glitch got=%h exp=%h", seen, ev); end
      seen = 1'b0;
      lat = -1;
      gpio_in[0] = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         @(posedge pclk);
         #1 if (gpio_alt_in[0] && !seen) begin seen = 1'b1; lat = c; end
      end
      exp_q.push_back(32'd1);
      ev = exp_q.pop_front(); n_checks++;
      if ({31'd0, (lat >= SYNC_STAGE + 12 && lat <= SYNC_STAGE + 17)} !== ev) begin
         n_fail++; $display("FAIL db_latency got=%0d exp=%0d..%0d", lat, SYNC_STAGE + 12, SYNC_STAGE + 17);
      end
      exp_q.push_back(32'h1);
      apb_read(4'd1, rd);
      ev = exp_q.pop_front(); n_checks++;
      if (rd !== ev) begin n_fail++; $display("FAIL db_padin got=%h exp=%h", rd, ev); end
      gpio_in[0] = 1'b0;
      wait_cycles(40);
      apb_write(4'd12, 32'h0);
      apb_write(4'd13, 32'h0);
      gpio_in[5] = 1'b1;
      wait_cycles(SYNC_STAGE + 1);
      exp_q.push_back(32'h20);
      ev = exp_q.pop_front(); n_checks++;
      if (32'(gpio_alt_in) !== ev) begin n_fail++; $display("FAIL db_bypass got=%h exp=%h", gpio_alt_in, ev); end
      gpio_in[5] = 1'b0;
      wait_cycles(SYNC_STAGE + 1);
   endtask

   task automatic test_iof_reset();
      logic [31:0] rd, ev;
      alt0_out = 32'h2; alt0_dir = 32'h2;
      alt1_out = 32'h1; alt1_dir = 32'h1;
      apb_write(4'd2, 32'hF0);
      apb_write(4'd0, 32'hF0);
      apb_write(4'd10, 32'h3);
      apb_write(4'd11, 32'h1);
      exp_q.push_back(32'hF3);
      ev = exp_q.pop_front(); n_checks++;
      if (32'(gpio_out) !== ev) begin n_fail++; $display("FAIL iof_out got=%h exp=%h", gpio_out, ev); end
      exp_q.push_back(32'hF3);
      ev = exp_q.pop_front(); n_checks++;
      if (32'(gpio_dir) !== ev) begin n_fail++; $display("FAIL iof_dir got=%h exp=%h", gpio_dir, ev); end
      apb_write(4'd11, 32'h3);
      exp_q.push_back(32'hF1);
      ev = exp_q.pop_front(); n_checks++;
      if (32'(gpio_out) !== ev) begin n_fail++; $display("FAIL pinmux_out got=%h exp=%h", gpio_out, ev); end
      apb_write(4'd5, 32'h10);
      gpio_in[4] = 1'b1;
      wait_cycles(SYNC_STAGE + 3);
      exp_q.push_back(32'd1);
      ev = exp_q.pop_front(); n_checks++;
      if ({31'd0, irq} !== ev) begin n_fail++; $display("FAIL pre_rst_irq got=%h exp=%h", irq, ev); end
      @(negedge pclk);
      #2 preset = 1'b1;
      #1;
      exp_q.push_back(32'd0);
      ev = exp_q.pop_front(); n_checks++;
      if ({irq, gpio_out, gpio_dir} !== {1'b0, ev, ev}) begin
         n_fail++; $display("FAIL async_rst got out=%h dir=%h irq=%b exp=%h", gpio_out, gpio_dir, irq, ev);
      end
      gpio_in[4] = 1'b0;
      wait_cycles(2);
      preset = 1'b0;
      exp_q.push_back(32'd0);
      apb_read(4'd10, rd);
      ev = exp_q.pop_front(); n_checks++;
      if (rd !== ev) begin n_fail++; $display("FAIL rst_iofcfg got=%h exp=%h", rd, ev); end
      exp_q.push_back(32'd0);
      apb_read(4'd9, rd);
      ev = exp_q.pop_front(); n_checks++;
      if (rd !== ev) begin n_fail++; $display("FAIL rst_intstat got=%h exp=%h", rd, ev); end
   endtask

   initial begin
      preset = 1'b1;
      gpio_in = '0;
      alt0_out = '0; alt1_out = '0; alt0_dir = '0; alt1_dir = '0;
      bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
      bus.paddr = '0; bus.pwdata = '0;
      test_reset();
      test_set_clr();
      test_rise_latency();
      test_any_edge();
      test_level();
      test_debounce();
      test_iof_reset();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
